// File: rtl/pc_fetch_sequencer.sv
// Instruction fetch front end: holds the PC, keeps one memory read in flight,
// and buffers the returned word for decode. Redirects squash stale responses.
module pc_fetch_sequencer #(
  parameter int                 WIDTH    = 16,
  parameter logic [WIDTH-1:0]   RESET_PC = '0,
  parameter int                 STEP     = 1
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Fetch_Enable,
  input  logic             Redirect,
  input  logic [WIDTH-1:0] Redirect_PC,
  output logic             Mem_Req,
  output logic [WIDTH-1:0] Mem_Addr,
  input  logic             Mem_Ack,
  input  logic             Mem_Rvalid,
  input  logic [WIDTH-1:0] Mem_Rdata,
  output logic             Instr_Valid,
  output logic [WIDTH-1:0] Instr,
  output logic [WIDTH-1:0] Instr_PC,
  input  logic             Instr_Ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(STEP);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;
  logic             squash_q, squash_d;
  logic             instr_valid_q, instr_valid_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic             buf_free;

  assign buf_free = !instr_valid_q || Instr_Ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    squash_d      = squash_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;

    if (Redirect) begin
      // A redirect wins over every handshake; only the request/response
      // bookkeeping needed to discard the stale fetch is kept.
      pc_d          = Redirect_PC;
      instr_valid_d = 1'b0;
      case (state_q)
        S_ISSUE: begin
          if (Mem_Ack) begin
            state_d  = S_WAIT;
            squash_d = 1'b1;
          end
        end
        S_WAIT: begin
          if (Mem_Rvalid) begin
            state_d  = S_IDLE;
            squash_d = 1'b0;
          end else begin
            squash_d = 1'b1;
          end
        end
        default: ;
      endcase
    end else begin
      if (instr_valid_q && Instr_Ready) begin
        instr_valid_d = 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (Fetch_Enable && buf_free) begin
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (Mem_Ack) begin
            state_d  = S_WAIT;
            req_pc_d = pc_q;
          end
        end
        S_WAIT: begin
          if (Mem_Rvalid) begin
            state_d = S_IDLE;
            if (squash_q) begin
              squash_d = 1'b0;
            end else begin
              instr_d       = Mem_Rdata;
              instr_pc_d    = req_pc_q;
              instr_valid_d = 1'b1;
              pc_d          = pc_q + PC_STEP;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      req_pc_q      <= RESET_PC;
      squash_q      <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      squash_q      <= squash_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  assign Mem_Req     = (state_q == S_ISSUE);
  assign Mem_Addr    = pc_q;
  assign Instr_Valid = instr_valid_q;
  assign Instr       = instr_q;
  assign Instr_PC    = instr_pc_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: a default instance plus one whose
// reset PC sits just below the wrap point.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, RESET_PC = 0
  logic        rst_n, fe, redir, ack, rvalid, ready;
  logic [15:0] redir_pc, rdata;
  logic        req, ivalid;
  logic [15:0] addr, instr, ipc;

  // Wrap-around instance, RESET_PC = FFFE
  logic        b_rst_n, b_fe, b_ack, b_rvalid, b_ready;
  logic [15:0] b_rdata;
  logic        b_req, b_ivalid;
  logic [15:0] b_addr, b_instr, b_ipc;

  int n_checks = 0;
  int n_fail   = 0;

  pc_fetch_sequencer #(.WIDTH(16), .RESET_PC(16'h0000), .STEP(1)) dut (
    .Clock(clk), .Reset_n(rst_n), .Fetch_Enable(fe), .Redirect(redir),
    .Redirect_PC(redir_pc), .Mem_Req(req), .Mem_Addr(addr), .Mem_Ack(ack),
    .Mem_Rvalid(rvalid), .Mem_Rdata(rdata), .Instr_Valid(ivalid),
    .Instr(instr), .Instr_PC(ipc), .Instr_Ready(ready)
  );

  pc_fetch_sequencer #(.WIDTH(16), .RESET_PC(16'hFFFE), .STEP(1)) dut_wrap (
    .Clock(clk), .Reset_n(b_rst_n), .Fetch_Enable(b_fe), .Redirect(1'b0),
    .Redirect_PC(16'h0000), .Mem_Req(b_req), .Mem_Addr(b_addr), .Mem_Ack(b_ack),
    .Mem_Rvalid(b_rvalid), .Mem_Rdata(b_rdata), .Instr_Valid(b_ivalid),
    .Instr(b_instr), .Instr_PC(b_ipc), .Instr_Ready(b_ready)
  );

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts with the main DUT in ISSUE at exp_addr; ends with the word buffered.
  task automatic fetch_one(input logic [15:0] exp_addr, input logic [15:0] data);
    check_val("issue_req", {15'd0, req}, 16'd1);
    check_val("issue_addr", addr, exp_addr);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check_val("wait_req", {15'd0, req}, 16'd0);
    rvalid = 1'b1;
    rdata  = data;
    step();
    rvalid = 1'b0;
    rdata  = 16'h0000;
    check_val("load_valid", {15'd0, ivalid}, 16'd1);
    check_val("load_instr", instr, data);
    check_val("load_pc", ipc, exp_addr);
  endtask

  initial begin
    rst_n = 1'b0; fe = 1'b0; redir = 1'b0; redir_pc = 16'h0000;
    ack = 1'b0; rvalid = 1'b0; rdata = 16'h0000; ready = 1'b0;
    b_rst_n = 1'b0; b_fe = 1'b0; b_ack = 1'b0; b_rvalid = 1'b0;
    b_rdata = 16'h0000; b_ready = 1'b0;

    // Reset values
    step(); step();
    check_val("rst_req", {15'd0, req}, 16'd0);
    check_val("rst_addr", addr, 16'h0000);
    check_val("rst_valid", {15'd0, ivalid}, 16'd0);
    check_val("rst_instr", instr, 16'h0000);
    check_val("rst_ipc", ipc, 16'h0000);
    check_val("wrap_rst_addr", b_addr, 16'hFFFE);

    // Fetch disabled: no request leaves IDLE
    rst_n = 1'b1;
    step(); step();
    check_val("fe0_req", {15'd0, req}, 16'd0);

    // Streaming fetch of words 0..3 with decode always ready
    fe = 1'b1; ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      fetch_one(16'(i), 16'h1000 + 16'(i));
      step();
      check_val("drain_valid", {15'd0, ivalid}, 16'd0);
    end
    check_val("stream_next_addr", addr, 16'h0004);

    // Backpressure: reset, fetch one word, hold decode off for 5 cycles
    rst_n = 1'b0; ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    fetch_one(16'h0000, 16'hBEEF);
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("bp_req", {15'd0, req}, 16'd0);
      check_val("bp_instr", instr, 16'hBEEF);
      check_val("bp_ipc", ipc, 16'h0000);
      check_val("bp_valid", {15'd0, ivalid}, 16'd1);
    end
    ready = 1'b1;
    step();
    check_val("bp_resume_req", {15'd0, req}, 16'd1);
    check_val("bp_resume_addr", addr, 16'h0001);
    check_val("bp_resume_valid", {15'd0, ivalid}, 16'd0);

    // Redirect during WAIT: the in-flight DEAD response must be squashed
    ack = 1'b1;
    step();
    ack = 1'b0;
    redir = 1'b1; redir_pc = 16'h0040;
    step();
    redir = 1'b0;
    check_val("wr_req", {15'd0, req}, 16'd0);
    step();
    rvalid = 1'b1; rdata = 16'hDEAD;
    step();
    rvalid = 1'b0; rdata = 16'h0000;
    check_val("wr_valid", {15'd0, ivalid}, 16'd0);
    check_val("wr_instr", instr, 16'hBEEF);
    step();
    check_val("wr_next_req", {15'd0, req}, 16'd1);
    check_val("wr_next_addr", addr, 16'h0040);

    // Redirect in ISSUE with ack withheld: address moves, request stays up
    redir = 1'b1; redir_pc = 16'h0100;
    step();
    redir = 1'b0;
    fetch_one(16'h0100, 16'h5A5A);
    step();
    check_val("ri_next_addr", addr, 16'h0101);

    // Redirect coinciding with ack: response is dropped, refetch at target
    ack = 1'b1; redir = 1'b1; redir_pc = 16'h0200;
    step();
    ack = 1'b0; redir = 1'b0;
    rvalid = 1'b1; rdata = 16'h7777;
    step();
    rvalid = 1'b0; rdata = 16'h0000;
    check_val("ra_valid", {15'd0, ivalid}, 16'd0);
    step();
    fetch_one(16'h0200, 16'h2222);
    step();

    // Reset during WAIT with the response arriving while still in reset
    ack = 1'b1;
    step();
    ack = 1'b0;
    rst_n = 1'b0;
    step();
    rvalid = 1'b1; rdata = 16'hCAFE;
    step();
    rvalid = 1'b0; rdata = 16'h0000;
    check_val("rw_req", {15'd0, req}, 16'd0);
    check_val("rw_addr", addr, 16'h0000);
    check_val("rw_valid", {15'd0, ivalid}, 16'd0);
    check_val("rw_instr", instr, 16'h0000);
    check_val("rw_ipc", ipc, 16'h0000);
    rst_n = 1'b1;
    step();
    fetch_one(16'h0000, 16'h3333);

    // PC wrap from FFFE on the second instance
    b_rst_n = 1'b1; b_fe = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [15:0] exp_pc;
      exp_pc = 16'hFFFE + 16'(i);
      step();
      check_val("wrap_req", {15'd0, b_req}, 16'd1);
      check_val("wrap_addr", b_addr, exp_pc);
      b_ack = 1'b1;
      step();
      b_ack = 1'b0;
      b_rvalid = 1'b1; b_rdata = 16'hA000 + 16'(i);
      step();
      b_rvalid = 1'b0;
      check_val("wrap_ipc", b_ipc, exp_pc);
      check_val("wrap_instr", b_instr, 16'hA000 + 16'(i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
